// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter feeding the 4-digit display driver.
// Optional build macro BIN_TO_BCD_OVERFLOW_BLANK_EN: show "EEEE" when the value exceeds 9999.
//
// state | meaning
// IDLE  | waiting for iwStart; digits hold last result
// SHIFT | one add-3/shift iteration per clock, pWidth iterations total
// DONE  | publish digits and overflow, pulse orDone
module bin_to_bcd_converter #(
  parameter int pWidth = 16
) (
  input  logic              iwClk,
  input  logic              iwRst,
  input  logic              iwStart,
  input  logic [pWidth-1:0] iwValue,
  output logic [3:0]        orDigit0,
  output logic [3:0]        orDigit1,
  output logic [3:0]        orDigit2,
  output logic [3:0]        orDigit3,
  output logic              orBusy,
  output logic              orDone,
  output logic              orOverflow
);

  localparam int CW = $clog2(pWidth + 1);
  localparam logic [CW-1:0] LAST = CW'(pWidth - 1);

  generate
    if (pWidth < 4 || pWidth > 16) begin : g_bad_width
      $error("bin_to_bcd_converter: pWidth must be within 4..16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [pWidth-1:0]   rShift;
  logic [19:0]         rAcc;
  logic [CW-1:0]       rCnt;
  logic [19:0]         wAdj;
  logic [19+pWidth:0]  wPair;
  logic                wLast;
  logic                wOvf;

  always_comb begin
    wAdj = rAcc;
    for (int i = 0; i < 5; i++) begin
      if (rAcc[4*i +: 4] >= 4'd5) wAdj[4*i +: 4] = rAcc[4*i +: 4] + 4'd3;
    end
    wPair = {wAdj, rShift} << 1;
    wLast = (rCnt == LAST);
    wOvf  = (rAcc[19:16] != 4'd0);
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iwStart) state_nxt = SHIFT;
      SHIFT:   if (wLast) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      rShift     <= '0;
      rAcc       <= '0;
      rCnt       <= '0;
      orDigit0   <= 4'd0;
      orDigit1   <= 4'd0;
      orDigit2   <= 4'd0;
      orDigit3   <= 4'd0;
      orBusy     <= 1'b0;
      orDone     <= 1'b0;
      orOverflow <= 1'b0;
    end else begin
      orDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iwStart) begin
            rShift <= iwValue;
            rAcc   <= '0;
            rCnt   <= '0;
            orBusy <= 1'b1;
          end
        end
        SHIFT: begin
          rAcc   <= wPair[19+pWidth -: 20];
          rShift <= wPair[pWidth-1:0];
          rCnt   <= rCnt + CW'(1);
        end
        DONE: begin
`ifdef BIN_TO_BCD_OVERFLOW_BLANK_EN
          if (wOvf) begin
            orDigit0 <= 4'hE;
            orDigit1 <= 4'hE;
            orDigit2 <= 4'hE;
            orDigit3 <= 4'hE;
          end else begin
            orDigit0 <= rAcc[3:0];
            orDigit1 <= rAcc[7:4];
            orDigit2 <= rAcc[11:8];
            orDigit3 <= rAcc[15:12];
          end
`else
          // Without blanking the display shows the value modulo 10000.
          orDigit0 <= rAcc[3:0];
          orDigit1 <= rAcc[7:4];
          orDigit2 <= rAcc[11:8];
          orDigit3 <= rAcc[15:12];
`endif
          orOverflow <= wOvf;
          orDone     <= 1'b1;
          orBusy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter (pWidth=16): vector table, random values
// against an arithmetic reference, plus busy-start, held-start and reset-abort sequences.
module tb_bin_to_bcd_converter;

  logic        iwClk = 1'b0;
  logic        iwRst;
  logic        iwStart;
  logic [15:0] iwValue;
  logic [3:0]  orDigit0, orDigit1, orDigit2, orDigit3;
  logic        orBusy, orDone, orOverflow;

  int tests = 0;
  int fails = 0;

  bin_to_bcd_converter #(.pWidth(16)) dut (
    .iwClk(iwClk), .iwRst(iwRst), .iwStart(iwStart), .iwValue(iwValue),
    .orDigit0(orDigit0), .orDigit1(orDigit1), .orDigit2(orDigit2), .orDigit3(orDigit3),
    .orBusy(orBusy), .orDone(orDone), .orOverflow(orOverflow)
  );

  always #5 iwClk = ~iwClk;

  typedef struct {
    logic [15:0] value;
    logic [15:0] digits;  // {d3,d2,d1,d0}
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_digits(input int v);
    int m;
`ifdef BIN_TO_BCD_OVERFLOW_BLANK_EN
    if (v > 9999) return 16'hEEEE;
`endif
    m = v % 10000;
    return {4'((m / 1000) % 10), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] dig();
    return {orDigit3, orDigit2, orDigit1, orDigit0};
  endfunction

  // Start on edge E, verify busy window E..E+16, result and done pulse at E+17, done low at E+18.
  task automatic convert(input logic [15:0] v, input logic [15:0] exp_d, input logic exp_o,
                         input string nm);
    logic ok;
    @(negedge iwClk);
    iwValue = v;
    iwStart = 1'b1;
    @(posedge iwClk);
    #1;
    iwStart = 1'b0;
    iwValue = 16'($urandom);
    ok = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge iwClk);
      if (!orBusy || orDone) ok = 1'b0;
    end
    chk({nm, "_busy_window"}, 32'(ok), 32'd1);
    @(negedge iwClk);
    chk({nm, "_done"}, 32'(orDone), 32'd1);
    chk({nm, "_busy_low"}, 32'(orBusy), 32'd0);
    chk({nm, "_digits"}, 32'(dig()), 32'(exp_d));
    chk({nm, "_ovf"}, 32'(orOverflow), 32'(exp_o));
    @(negedge iwClk);
    chk({nm, "_done_drop"}, 32'(orDone), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses[$];
    int cyc;
    logic ok;
    logic [15:0] rv;

    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd0,     16'h0000, 1'b0};
    vecs[2] = '{16'd9999,  16'h9999, 1'b0};
    vecs[3] = '{16'd1,     16'h0001, 1'b0};
`ifdef BIN_TO_BCD_OVERFLOW_BLANK_EN
    vecs[4] = '{16'd12345, 16'hEEEE, 1'b1};
    vecs[5] = '{16'd65535, 16'hEEEE, 1'b1};
    vecs[6] = '{16'd10000, 16'hEEEE, 1'b1};
`else
    vecs[4] = '{16'd12345, 16'h2345, 1'b1};
    vecs[5] = '{16'd65535, 16'h5535, 1'b1};
    vecs[6] = '{16'd10000, 16'h0000, 1'b1};
`endif

    iwRst = 1'b1;
    iwStart = 1'b0;
    iwValue = '0;
    repeat (2) @(posedge iwClk);
    #2;
    chk("reset_digits", 32'(dig()), 32'd0);
    chk("reset_busy", 32'(orBusy), 32'd0);
    chk("reset_done", 32'(orDone), 32'd0);
    chk("reset_ovf", 32'(orOverflow), 32'd0);
    @(negedge iwClk);
    iwRst = 1'b0;

    foreach (vecs[k]) convert(vecs[k].value, vecs[k].digits, vecs[k].ovf, $sformatf("vec%0d", k));

    for (int k = 0; k < 20; k++) begin
      rv = 16'($urandom_range(0, 65535));
      convert(rv, model_digits(int'(rv)), rv > 16'd9999, $sformatf("rand%0d_%0d", k, rv));
    end

    // Start ignored while busy: 42 accepted, 7 pulsed at E+5.
    @(negedge iwClk);
    iwValue = 16'd42;
    iwStart = 1'b1;
    @(posedge iwClk);
    #1 iwStart = 1'b0;
    repeat (4) @(posedge iwClk);
    @(negedge iwClk);
    iwValue = 16'd7;
    iwStart = 1'b1;
    @(posedge iwClk);
    #1 iwStart = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge iwClk);
      if (orDone) ok = 1'b1;
    end
    chk("busy_start_done_seen", 32'(ok), 32'd1);
    chk("busy_start_digits", 32'(dig()), 32'h0042);
    ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge iwClk);
      if (orDone || orBusy || dig() != 16'h0042) ok = 1'b0;
    end
    chk("busy_start_ignored_hold", 32'(ok), 32'd1);

    // Held start: conversions repeat every pWidth+2 = 18 cycles.
    @(negedge iwClk);
    iwValue = 16'd321;
    iwStart = 1'b1;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge iwClk);
      cyc++;
      if (orDone) pulses.push_back(cyc);
    end
    iwStart = 1'b0;
    chk("held_start_pulses", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("held_start_first", 32'(pulses[0]), 32'd18);
      chk("held_start_period1", 32'(pulses[1] - pulses[0]), 32'd18);
      chk("held_start_period2", 32'(pulses[2] - pulses[1]), 32'd18);
    end
    chk("held_start_digits", 32'(dig()), 32'h0321);
    repeat (20) @(posedge iwClk);

    // Reset at E+8 while converting 500 aborts with no done and zeroed digits.
    @(negedge iwClk);
    iwValue = 16'd500;
    iwStart = 1'b1;
    @(posedge iwClk);
    #1 iwStart = 1'b0;
    repeat (8) @(posedge iwClk);
    #3 iwRst = 1'b1;
    #1;
    chk("abort_async_digits", 32'(dig()), 32'd0);
    chk("abort_async_busy", 32'(orBusy), 32'd0);
    chk("abort_async_done", 32'(orDone), 32'd0);
    repeat (2) @(posedge iwClk);
    @(negedge iwClk);
    iwRst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge iwClk);
      if (orDone || orBusy || dig() != 16'h0000) ok = 1'b0;
    end
    chk("abort_no_done", 32'(ok), 32'd1);
    convert(16'd500, 16'h0500, 1'b0, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
